// File: rtl/pid_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pid_ctrl_pkg
//  Purpose  : Shared state encoding and constants for the PID sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MEAS = 3'd1,
        ST_ITERATE   = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_CONFIG    = 3'd4
    } pid_state_t;

    localparam logic [1:0] KP_ADDR  = 2'd0;
    localparam logic [1:0] KI_ADDR  = 2'd1;
    localparam logic [1:0] KD1_ADDR = 2'd2;
    localparam logic [1:0] KD2_ADDR = 2'd3;

    localparam int MIN_PERIOD = 4;

endpackage
`default_nettype wire

// File: rtl/pid_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pid_tick_gen
//  Purpose  : Sample-period counter; tick marks the last count of each period.
//  Revision : 1.0  initial release
// ============================================================================
module pid_tick_gen
    import pid_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] c_MIN_PERIOD = DIV_WIDTH'(MIN_PERIOD);
    localparam logic [DIV_WIDTH-1:0] c_ONE        = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] w_period_clamped;
    logic [DIV_WIDTH-1:0] w_last;

    assign w_period_clamped = (period < c_MIN_PERIOD) ? c_MIN_PERIOD : period;
    assign w_last           = r_period - c_ONE;
    assign tick             = enable && (r_count == w_last);

    // The active period is only reloaded at a wrap (or while idle), so a
    // mid-period change never truncates or stretches the running period.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_period <= c_MIN_PERIOD;
        end else if (!enable) begin
            r_count  <= '0;
            r_period <= w_period_clamped;
        end else if (tick) begin
            r_count  <= '0;
            r_period <= w_period_clamped;
        end else begin
            r_count  <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pid_sequencer
//  Purpose  : Schedules PID iterations at a sample rate and serialises gain writes.
//  Revision : 1.0  initial release
// ============================================================================
module pid_sequencer
    import pid_ctrl_pkg::*;
#(
    parameter int D_WIDTH      = 18,
    parameter int DIV_WIDTH    = 16,
    parameter int MEAS_TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DIV_WIDTH-1:0]      period,
    input  logic signed [D_WIDTH-1:0] target_in,
    input  logic signed [D_WIDTH-1:0] meas_data,
    input  logic                      meas_valid,
    output logic                      meas_ready,
    input  logic                      cfg_valid,
    input  logic [1:0]                cfg_addr,
    input  logic signed [D_WIDTH-1:0] cfg_data,
    output logic                      cfg_ready,
    output logic                      pid_write_n,
    output logic [D_WIDTH-1:0]        pid_reg_addr,
    output logic signed [D_WIDTH-1:0] pid_reg_data,
    output logic                      pid_iterate,
    output logic signed [D_WIDTH-1:0] pid_target,
    output logic signed [D_WIDTH-1:0] pid_measurement,
    input  logic signed [D_WIDTH-1:0] pid_out,
    output logic signed [D_WIDTH-1:0] ctrl_out,
    output logic                      ctrl_valid,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int c_TO_W = ($clog2(MEAS_TIMEOUT + 1) > 8) ? $clog2(MEAS_TIMEOUT + 1) : 8;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MEAS_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = {c_TO_W{1'b1}};
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    pid_state_t r_state;
    pid_state_t w_state_next;

    logic                      w_tick;
    logic                      r_pending;
    logic                      w_pending_next;
    logic [c_TO_W-1:0]         r_wait_cnt;
    logic                      w_wait_expired;
    logic                      w_meas_accept;
    logic                      w_cfg_accept;
    logic                      w_overrun_next;
    logic                      w_timeout_next;

    logic                      r_meas_ready;
    logic                      r_iterate;
    logic                      r_write_n;
    logic [D_WIDTH-1:0]        r_reg_addr;
    logic signed [D_WIDTH-1:0] r_reg_data;
    logic signed [D_WIDTH-1:0] r_target;
    logic signed [D_WIDTH-1:0] r_measurement;
    logic signed [D_WIDTH-1:0] r_ctrl_out;
    logic                      r_ctrl_valid;
    logic                      r_overrun;
    logic                      r_timeout;

    pid_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .tick   (w_tick)
    );

    assign w_wait_expired = (r_wait_cnt >= c_TO_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_meas_accept  = 1'b0;
        w_cfg_accept   = 1'b0;
        w_overrun_next = 1'b0;
        w_timeout_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_tick || (r_pending && enable)) begin
                    w_state_next   = ST_WAIT_MEAS;
                    w_pending_next = 1'b0;
                    // A fresh tick arriving alongside a pending one is dropped
                    w_overrun_next = w_tick && r_pending;
                end else if (cfg_valid) begin
                    w_cfg_accept = 1'b1;
                    w_state_next = ST_CONFIG;
                end
            end
            ST_WAIT_MEAS: begin
                w_overrun_next = w_tick;
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (meas_valid && r_meas_ready) begin
                    w_meas_accept = 1'b1;
                    w_state_next  = ST_ITERATE;
                end else if (w_wait_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            ST_ITERATE: begin
                w_overrun_next = w_tick;
                w_state_next   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_overrun_next = w_tick;
                w_state_next   = ST_IDLE;
            end
            ST_CONFIG: begin
                if (w_tick) begin
                    w_overrun_next = r_pending;
                    w_pending_next = 1'b1;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (!enable) begin
            w_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pending     <= 1'b0;
            r_wait_cnt    <= '0;
            r_meas_ready  <= 1'b0;
            r_iterate     <= 1'b0;
            r_write_n     <= 1'b1;
            r_reg_addr    <= '0;
            r_reg_data    <= '0;
            r_target      <= '0;
            r_measurement <= '0;
            r_ctrl_out    <= '0;
            r_ctrl_valid  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pending    <= w_pending_next;
            r_meas_ready <= (w_state_next == ST_WAIT_MEAS);
            r_iterate    <= (w_state_next == ST_ITERATE);
            r_write_n    <= (w_state_next != ST_CONFIG);
            r_overrun    <= w_overrun_next;
            r_timeout    <= w_timeout_next;
            r_ctrl_valid <= (r_state == ST_CAPTURE);

            // Counts cycles spent in WAIT_MEAS; zero on entry
            if (r_state != ST_WAIT_MEAS) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_TO_MAX) begin
                r_wait_cnt <= r_wait_cnt + c_TO_ONE;
            end

            if (w_meas_accept) begin
                r_target      <= target_in;
                r_measurement <= meas_data;
            end
            if (w_cfg_accept) begin
                r_reg_addr <= D_WIDTH'(cfg_addr);
                r_reg_data <= cfg_data;
            end
            if (r_state == ST_CAPTURE) begin
                r_ctrl_out <= pid_out;
            end
        end
    end

    // Gain writes are only offered when no sample is due this cycle or waiting
    assign cfg_ready       = !reset && (r_state == ST_IDLE) && !w_tick && !r_pending;
    assign meas_ready      = r_meas_ready;
    assign pid_write_n     = r_write_n;
    assign pid_reg_addr    = r_reg_addr;
    assign pid_reg_data    = r_reg_data;
    assign pid_iterate     = r_iterate;
    assign pid_target      = r_target;
    assign pid_measurement = r_measurement;
    assign ctrl_out        = r_ctrl_out;
    assign ctrl_valid      = r_ctrl_valid;
    assign overrun         = r_overrun;
    assign timeout_err     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_sequencer
//  Purpose  : Directed self-checking bench for pid_sequencer with a PID stub.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pid_sequencer;
    import pid_ctrl_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [15:0]        period;
    logic signed [17:0] target_in;
    logic signed [17:0] meas_data;
    logic               meas_valid;
    logic               meas_ready;
    logic               cfg_valid;
    logic [1:0]         cfg_addr;
    logic signed [17:0] cfg_data;
    logic               cfg_ready;
    logic               pid_write_n;
    logic [17:0]        pid_reg_addr;
    logic signed [17:0] pid_reg_data;
    logic               pid_iterate;
    logic signed [17:0] pid_target;
    logic signed [17:0] pid_measurement;
    logic signed [17:0] pid_out;
    logic signed [17:0] ctrl_out;
    logic               ctrl_valid;
    logic               overrun;
    logic               timeout_err;

    logic signed [17:0] model_val;
    int checks   = 0;
    int errors   = 0;
    int ovr_cnt  = 0;
    int it_cnt   = 0;
    int conflict = 0;

    pid_sequencer u_dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .period          (period),
        .target_in       (target_in),
        .meas_data       (meas_data),
        .meas_valid      (meas_valid),
        .meas_ready      (meas_ready),
        .cfg_valid       (cfg_valid),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_ready       (cfg_ready),
        .pid_write_n     (pid_write_n),
        .pid_reg_addr    (pid_reg_addr),
        .pid_reg_data    (pid_reg_data),
        .pid_iterate     (pid_iterate),
        .pid_target      (pid_target),
        .pid_measurement (pid_measurement),
        .pid_out         (pid_out),
        .ctrl_out        (ctrl_out),
        .ctrl_valid      (ctrl_valid),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    always #5 clock = ~clock;

    // PID stub: out_clocked updates on the edge that samples iterate
    always @(posedge clock) begin
        if (reset) pid_out <= '0;
        else if (pid_iterate) pid_out <= model_val;
    end

    always @(negedge clock) begin
        if (overrun) ovr_cnt++;
        if (pid_iterate) it_cnt++;
        if (!pid_write_n && pid_iterate) conflict++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; period = 16'd10; target_in = '0; meas_data = '0;
        meas_valid = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = '0; model_val = '0;
        step(); step();
        checks++;
        if ({meas_ready, cfg_ready, pid_write_n, pid_iterate, ctrl_valid, overrun, timeout_err} !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0010000",
                     {meas_ready, cfg_ready, pid_write_n, pid_iterate, ctrl_valid, overrun, timeout_err});
        end
        checks++;
        if ({pid_target, pid_measurement, ctrl_out, pid_reg_addr, pid_reg_data} !== 90'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {pid_target, pid_measurement, ctrl_out, pid_reg_addr, pid_reg_data});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_periodic();
        int prev = -1;
        int n_iter = 0;
        int n_mr = 0;
        period = 16'd10; meas_valid = 1'b1; meas_data = 18'sd7; target_in = 18'sd5; model_val = 18'sd123;
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step();
            if (meas_ready) n_mr++;
            if (pid_iterate) begin
                checks++;
                if (pid_target !== 18'sd5 || pid_measurement !== 18'sd7) begin
                    errors++;
                    $display("FAIL periodic_latch got tgt=%0d meas=%0d exp 5/7", pid_target, pid_measurement);
                end
                checks++;
                if ((prev < 0 && i != 10) || (prev >= 0 && i - prev != 10)) begin
                    errors++;
                    $display("FAIL periodic_spacing iterate at %0d prev %0d exp first 10 then every 10", i, prev);
                end
                prev = i;
                n_iter++;
            end
            if (ctrl_valid) begin
                checks++;
                if (ctrl_out !== 18'sd123 || i != prev + 2) begin
                    errors++;
                    $display("FAIL periodic_ctrl got out=%0d at %0d exp 123 at %0d", ctrl_out, i, prev + 2);
                end
            end
        end
        checks++;
        if (n_iter != 4 || n_mr != 4) begin
            errors++;
            $display("FAIL periodic_count got iter=%0d ready=%0d exp 4/4", n_iter, n_mr);
        end
        enable = 1'b0; meas_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_config();
        cfg_valid = 1'b1; cfg_addr = KI_ADDR; cfg_data = 18'sh00100;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready got %b exp 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (pid_write_n !== 1'b0 || pid_iterate !== 1'b0 || pid_reg_addr !== 18'd1 || pid_reg_data !== 18'sh00100) begin
            errors++;
            $display("FAIL cfg_write got wn=%b it=%b a=%h d=%h exp 0/0/1/100",
                     pid_write_n, pid_iterate, pid_reg_addr, pid_reg_data);
        end
        step();
        checks++;
        if (pid_write_n !== 1'b1 || pid_reg_data !== 18'sh00100 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_done got wn=%b d=%h rdy=%b exp 1/100/1", pid_write_n, pid_reg_data, cfg_ready);
        end
    endtask

    task automatic test_cfg_before_tick();
        int ovr0;
        period = 16'd8; meas_valid = 1'b0; enable = 1'b0;
        step();
        ovr0 = ovr_cnt;
        enable = 1'b1;
        repeat (6) step();
        cfg_valid = 1'b1; cfg_addr = KD1_ADDR; cfg_data = 18'sh0002A;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL pend_cfg_ready got %b exp 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (pid_write_n !== 1'b0 || cfg_ready !== 1'b0 || pid_reg_addr !== 18'd2) begin
            errors++;
            $display("FAIL pend_write got wn=%b rdy=%b a=%h exp 0/0/2", pid_write_n, cfg_ready, pid_reg_addr);
        end
        step();
        checks++;
        if (pid_write_n !== 1'b1 || meas_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL pend_idle got wn=%b mr=%b rdy=%b exp 1/0/0", pid_write_n, meas_ready, cfg_ready);
        end
        step();
        checks++;
        if (meas_ready !== 1'b1) begin
            errors++;
            $display("FAIL pend_wait got meas_ready=%b exp 1", meas_ready);
        end
        meas_valid = 1'b1; target_in = -18'sd3; meas_data = 18'sd11; model_val = 18'sd77;
        step();
        meas_valid = 1'b0;
        checks++;
        if (pid_iterate !== 1'b1 || pid_measurement !== 18'sd11 || pid_target !== -18'sd3) begin
            errors++;
            $display("FAIL pend_iter got it=%b meas=%0d tgt=%0d exp 1/11/-3", pid_iterate, pid_measurement, pid_target);
        end
        step(); step();
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_out !== 18'sd77 || ovr_cnt != ovr0) begin
            errors++;
            $display("FAIL pend_ctrl got cv=%b out=%0d ovr=%0d exp 1/77/0", ctrl_valid, ctrl_out, ovr_cnt - ovr0);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int to_at = -1;
        int n_to = 0;
        int n_mr = 0;
        int it0;
        int it_at = -1;
        period = 16'd300; meas_valid = 1'b0; enable = 1'b0;
        step();
        it0 = it_cnt;
        enable = 1'b1;
        for (int i = 1; i <= 560; i++) begin
            step();
            if (meas_ready) n_mr++;
            if (timeout_err) begin
                n_to++;
                if (to_at < 0) to_at = i;
            end
        end
        checks++;
        if (to_at != 555 || n_to != 1) begin
            errors++;
            $display("FAIL timeout_pulse got at=%0d n=%0d exp 555/1", to_at, n_to);
        end
        checks++;
        if (n_mr != 255 || it_cnt != it0) begin
            errors++;
            $display("FAIL timeout_wait got ready=%0d iter=%0d exp 255/0", n_mr, it_cnt - it0);
        end
        meas_valid = 1'b1; meas_data = 18'sd20; model_val = -18'sd5;
        for (int i = 561; i <= 700 && it_at < 0; i++) begin
            step();
            if (pid_iterate) it_at = i;
        end
        checks++;
        if (it_at != 601) begin
            errors++;
            $display("FAIL timeout_next_tick got iterate at %0d exp 601", it_at);
        end
        step(); step();
        checks++;
        if (ctrl_valid !== 1'b1 || ctrl_out !== -18'sd5) begin
            errors++;
            $display("FAIL timeout_ctrl got cv=%b out=%0d exp 1/-5", ctrl_valid, ctrl_out);
        end
        enable = 1'b0; meas_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_overrun();
        int ov_a = -1;
        int ov_b = -1;
        int n_ov = 0;
        int it_at = -1;
        int n_it = 0;
        int cv_at = -1;
        int it1;
        period = 16'd4; meas_valid = 1'b0; enable = 1'b0; model_val = 18'sd999;
        step();
        enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (overrun) begin
                n_ov++;
                if (ov_a < 0) ov_a = i; else ov_b = i;
            end
            if (pid_iterate) begin n_it++; it_at = i; end
            if (ctrl_valid) cv_at = i;
            if (i == 10) meas_valid = 1'b1;
        end
        enable = 1'b0; meas_valid = 1'b0;
        it1 = it_cnt;
        repeat (4) step();
        checks++;
        if (n_ov != 2 || ov_a != 8 || ov_b != 12) begin
            errors++;
            $display("FAIL overrun_pulses got n=%0d at %0d,%0d exp 2 at 8,12", n_ov, ov_a, ov_b);
        end
        checks++;
        if (n_it != 1 || it_at != 11 || cv_at != 13 || it_cnt != it1) begin
            errors++;
            $display("FAIL overrun_seq got it=%0d@%0d cv@%0d exp 1@11 cv@13", n_it, it_at, cv_at);
        end
        checks++;
        if (ctrl_out !== 18'sd999) begin
            errors++;
            $display("FAIL overrun_ctrl got %0d exp 999", ctrl_out);
        end
    endtask

    task automatic test_reset_mid();
        int it_a = -1;
        int it_b = -1;
        int it_c = -1;
        int n_cv = 0;
        period = 16'd2; meas_valid = 1'b1; meas_data = 18'sd4; target_in = 18'sd9; model_val = 18'sd55;
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (5) step();
        checks++;
        if (pid_iterate !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_iter got iterate=%b exp 1", pid_iterate);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({meas_ready, cfg_ready, pid_write_n, pid_iterate, ctrl_valid, overrun, timeout_err} !== 7'b0010000 ||
            {pid_target, pid_measurement, ctrl_out, pid_reg_addr, pid_reg_data} !== 90'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got ctrl=%b data=%h exp 0010000/0",
                     {meas_ready, cfg_ready, pid_write_n, pid_iterate, ctrl_valid, overrun, timeout_err},
                     {pid_target, pid_measurement, ctrl_out, pid_reg_addr, pid_reg_data});
        end
        reset = 1'b0;
        for (int i = 7; i <= 20; i++) begin
            step();
            if (ctrl_valid && i < 11) n_cv++;
            if (pid_iterate) begin
                if (it_a < 0) it_a = i;
                else if (it_b < 0) it_b = i;
                else if (it_c < 0) it_c = i;
            end
        end
        checks++;
        if (it_a != 11 || it_b != 15 || it_c != 19 || n_cv != 0) begin
            errors++;
            $display("FAIL rstmid_clamp got iterates %0d,%0d,%0d stray_cv=%0d exp 11,15,19 0", it_a, it_b, it_c, n_cv);
        end
        enable = 1'b0; meas_valid = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_config();
        test_cfg_before_tick();
        test_timeout();
        test_overrun();
        test_reset_mid();
        checks++;
        if (conflict != 0) begin
            errors++;
            $display("FAIL strobe_overlap got %0d cycles exp 0", conflict);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
